// File: rtl/biu_prefetch_ctrl.sv
// 8088-style bus interface sequencer: runs T1-T4 bus cycles on an 8-bit bus and
// arbitrates between EU data accesses and a byte-wide instruction prefetch queue.
module biu_prefetch_ctrl #(
  parameter int QUEUE_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cs_base,
  input  logic        ip_load,
  input  logic [15:0] ip_new,
  input  logic        q_pop,
  output logic [7:0]  q_byte,
  output logic        q_valid,
  input  logic        eu_req,
  input  logic        eu_wr,
  input  logic [15:0] eu_seg,
  input  logic [15:0] eu_off,
  input  logic [7:0]  eu_wdata,
  output logic        eu_ack,
  output logic [7:0]  eu_rdata,
  output logic [19:0] Direction,
  output logic        ale,
  output logic        RD_WR,
  output logic [7:0]  Data_out,
  output logic        Data_oe,
  input  logic [7:0]  Data_in,
  input  logic        ready
);

  localparam int AW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(QUEUE_DEPTH);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW-1:0] PTR_ZERO = {AW{1'b0}};
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_T1   = 3'd1;
  localparam logic [2:0] S_T2   = 3'd2;
  localparam logic [2:0] S_T3   = 3'd3;
  localparam logic [2:0] S_TW   = 3'd4;
  localparam logic [2:0] S_T4   = 3'd5;

  function automatic logic [19:0] phys_addr(input logic [15:0] seg, input logic [15:0] off);
    return {seg, 4'h0} + {4'h0, off};
  endfunction

  logic [2:0]    state_r, state_s;
  logic          is_eu_r, wr_r, discard_r, discard_s;
  logic [15:0]   fetch_ip_r, fetch_ip_s;
  logic [7:0]    bus_data_r;
  logic [7:0]    mem_r [QUEUE_DEPTH];
  logic [AW-1:0] head_r, tail_r;
  logic [CW-1:0] count_r, count_s;
  logic          arb_s, eu_req_s, eu_go_s, pf_go_s, launch_s;
  logic          push_s, pop_s, pf_done_s, in_data_s;

  logic [19:0]   dir_r;
  logic          ale_r, rd_wr_r, data_oe_r, eu_ack_r;
  logic [7:0]    data_out_r, eu_rdata_r;

  // Next-state, arbitration and queue bookkeeping
  always_comb begin
    arb_s     = (state_r == S_IDLE) || (state_r == S_T4);
    // the request being acked in T4 must not start a second EU cycle
    eu_req_s  = eu_req && !((state_r == S_T4) && is_eu_r);
    pf_done_s = (state_r == S_T4) && !is_eu_r && !discard_r;
    push_s    = pf_done_s && !ip_load;
    pop_s     = q_pop && (count_r != CNT_ZERO) && !ip_load;

    if (ip_load) begin
      count_s = CNT_ZERO;
    end else if (push_s && !pop_s) begin
      count_s = count_r + CNT_ONE;
    end else if (pop_s && !push_s) begin
      count_s = count_r - CNT_ONE;
    end else begin
      count_s = count_r;
    end

    if (ip_load) begin
      fetch_ip_s = ip_new;
    end else if (pf_done_s) begin
      fetch_ip_s = fetch_ip_r + 16'd1;
    end else begin
      fetch_ip_s = fetch_ip_r;
    end

    // eligibility uses the post-edge count so a completing fetch is accounted for
    eu_go_s  = arb_s && eu_req_s;
    pf_go_s  = arb_s && !eu_req_s && (count_s < DEPTH_C);
    launch_s = eu_go_s || pf_go_s;

    if (launch_s) begin
      discard_s = 1'b0;
    end else if (ip_load && (state_r != S_IDLE) && !is_eu_r) begin
      discard_s = 1'b1;
    end else begin
      discard_s = discard_r;
    end

    case (state_r)
      S_IDLE, S_T4: state_s = launch_s ? S_T1 : S_IDLE;
      S_T1:         state_s = S_T2;
      S_T2:         state_s = S_T3;
      S_T3, S_TW:   state_s = ready ? S_T4 : S_TW;
      default:      state_s = S_IDLE;
    endcase

    in_data_s = (state_s == S_T2) || (state_s == S_T3) ||
                (state_s == S_TW) || (state_s == S_T4);
  end

  // Bus sequencer state and per-cycle attributes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= S_IDLE;
      is_eu_r    <= 1'b0;
      wr_r       <= 1'b0;
      discard_r  <= 1'b0;
      fetch_ip_r <= 16'h0000;
      bus_data_r <= 8'h00;
    end else begin
      state_r    <= state_s;
      discard_r  <= discard_s;
      fetch_ip_r <= fetch_ip_s;
      if (launch_s) begin
        is_eu_r <= eu_go_s;
        wr_r    <= eu_go_s && eu_wr;
      end
      if (!is_eu_r && (state_s == S_T4) && (state_r != S_T4)) begin
        bus_data_r <= Data_in;
      end
    end
  end

  // Prefetch queue storage and pointers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        mem_r[i] <= 8'h00;
      end
      head_r  <= PTR_ZERO;
      tail_r  <= PTR_ZERO;
      count_r <= CNT_ZERO;
    end else begin
      count_r <= count_s;
      if (ip_load) begin
        head_r <= PTR_ZERO;
        tail_r <= PTR_ZERO;
      end else begin
        if (push_s) begin
          mem_r[tail_r] <= bus_data_r;
          tail_r        <= tail_r + PTR_ONE;
        end
        if (pop_s) begin
          head_r <= head_r + PTR_ONE;
        end
      end
    end
  end

  // Registered bus and EU-facing outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dir_r      <= 20'h00000;
      ale_r      <= 1'b0;
      rd_wr_r    <= 1'b0;
      data_oe_r  <= 1'b0;
      data_out_r <= 8'h00;
      eu_ack_r   <= 1'b0;
      eu_rdata_r <= 8'h00;
    end else begin
      ale_r     <= launch_s;
      rd_wr_r   <= wr_r && in_data_s && !launch_s;
      data_oe_r <= wr_r && in_data_s && !launch_s;
      eu_ack_r  <= is_eu_r && (state_s == S_T4) && (state_r != S_T4);
      if (launch_s) begin
        dir_r <= eu_go_s ? phys_addr(eu_seg, eu_off) : phys_addr(cs_base, fetch_ip_s);
      end
      if (eu_go_s && eu_wr) begin
        data_out_r <= eu_wdata;
      end
      if (is_eu_r && !wr_r && (state_s == S_T4) && (state_r != S_T4)) begin
        eu_rdata_r <= Data_in;
      end
    end
  end

  assign q_byte    = mem_r[head_r];
  assign q_valid   = (count_r != CNT_ZERO);
  assign Direction = dir_r;
  assign ale       = ale_r;
  assign RD_WR     = rd_wr_r;
  assign Data_oe   = data_oe_r;
  assign Data_out  = data_out_r;
  assign eu_ack    = eu_ack_r;
  assign eu_rdata  = eu_rdata_r;

endmodule

// File: tb/tb_biu_prefetch_ctrl.sv
// Directed bench for biu_prefetch_ctrl: bench-owned memory model, scoreboard
// queues for prefetched bytes and EU read data, immediate assertions at each check.
module tb_biu_prefetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cs_base, ip_new, eu_seg, eu_off;
  logic        ip_load, q_pop, eu_req, eu_wr, ready;
  logic [7:0]  eu_wdata;
  logic [7:0]  q_byte, eu_rdata, Data_out, Data_in;
  logic        q_valid, eu_ack, ale, RD_WR, Data_oe;
  logic [19:0] Direction;

  int n_assert = 0;
  int n_fail   = 0;
  logic [7:0] sb_q[$];
  logic [7:0] sb_eu[$];

  biu_prefetch_ctrl #(.QUEUE_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .cs_base(cs_base), .ip_load(ip_load), .ip_new(ip_new),
    .q_pop(q_pop), .q_byte(q_byte), .q_valid(q_valid), .eu_req(eu_req), .eu_wr(eu_wr),
    .eu_seg(eu_seg), .eu_off(eu_off), .eu_wdata(eu_wdata), .eu_ack(eu_ack),
    .eu_rdata(eu_rdata), .Direction(Direction), .ale(ale), .RD_WR(RD_WR),
    .Data_out(Data_out), .Data_oe(Data_oe), .Data_in(Data_in), .ready(ready)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_f(input logic [19:0] a);
    if (a == 20'h12350) return 8'hA5;
    return a[7:0] ^ a[19:12] ^ 8'h3C;
  endfunction

  assign Data_in = mem_f(Direction);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [19:0] base, input int n);
    for (int i = 0; i < n; i++) sb_q.push_back(mem_f(base + 20'(i)));
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < n; k++) begin
      int t = 0;
      logic [7:0] e;
      while (!q_valid && t < 50) begin
        tick();
        t++;
      end
      chk("drain_valid", {31'd0, q_valid}, 32'd1);
      e = (sb_q.size() > 0) ? sb_q.pop_front() : 8'hxx;
      chk("q_byte", {24'd0, q_byte}, {24'd0, e});
      q_pop = 1'b1;
      tick();
      q_pop = 1'b0;
    end
  endtask

  task automatic wait_quiet();
    int q = 0;
    for (int i = 0; i < 100 && q < 6; i++) begin
      tick();
      if (ale === 1'b0) q++;
      else q = 0;
    end
    chk("bus_quiet", {31'd0, (q >= 6)}, 32'd1);
  endtask

  task automatic pop_one();
    logic [7:0] e;
    e = (sb_q.size() > 0) ? sb_q.pop_front() : 8'hxx;
    chk("pop_byte", {24'd0, q_byte}, {24'd0, e});
    q_pop = 1'b1;
    tick();
    q_pop = 1'b0;
  endtask

  initial begin
    reset = 1'b0; cs_base = 16'hF000; ip_new = 16'h0000; ip_load = 1'b0; q_pop = 1'b0;
    eu_req = 1'b0; eu_wr = 1'b0; eu_seg = 16'h0; eu_off = 16'h0; eu_wdata = 8'h00; ready = 1'b1;
    tick(); tick();
    chk("rst_q_valid", {31'd0, q_valid}, 32'd0);
    chk("rst_dir", {12'd0, Direction}, 32'd0);
    chk("rst_ale", {31'd0, ale}, 32'd0);
    chk("rst_eu_ack", {31'd0, eu_ack}, 32'd0);

    // 1: prefetch fill from F000:FFF0
    ip_load = 1'b1; ip_new = 16'hFFF0;
    push_exp(20'hFFFF0, 4);
    #3 reset = 1'b1;
    tick();
    ip_load = 1'b0;
    chk("t1_ale", {31'd0, ale}, 32'd1);
    chk("t1_dir", {12'd0, Direction}, 32'h000FFFF0);
    chk("t1_rdwr", {31'd0, RD_WR}, 32'd0);
    repeat (3) tick();
    chk("t1_qv_early", {31'd0, q_valid}, 32'd0);
    tick();
    chk("t1_qv", {31'd0, q_valid}, 32'd1);
    chk("t1_dir2", {12'd0, Direction}, 32'h000FFFF1);
    repeat (8) tick();
    chk("t1_dir4", {12'd0, Direction}, 32'h000FFFF3);
    repeat (4) tick();
    chk("t1_full_idle", {31'd0, ale}, 32'd0);
    drain(4);
    wait_quiet();

    // 2: segment:offset wrap
    cs_base = 16'hFFFF; ip_new = 16'h0010; ip_load = 1'b1;
    sb_q.delete();
    push_exp(20'h00000, 9);
    tick();
    ip_load = 1'b0;
    chk("t2_ale", {31'd0, ale}, 32'd1);
    chk("t2_dir", {12'd0, Direction}, 32'h00000000);
    chk("t2_flush", {31'd0, q_valid}, 32'd0);
    repeat (4) tick();
    chk("t2_dir2", {12'd0, Direction}, 32'h00000001);
    drain(4);
    wait_quiet();

    // 3: EU read arriving during prefetch T2
    pop_one();
    chk("t3_pf_dir", {12'd0, Direction}, 32'h00000008);
    tick();
    eu_req = 1'b1; eu_wr = 1'b0; eu_seg = 16'h1234; eu_off = 16'h0010;
    sb_eu.push_back(mem_f(20'h12350));
    tick();
    chk("t3_no_preempt", {12'd0, Direction}, 32'h00000008);
    tick();
    chk("t3_pf_noack", {31'd0, eu_ack}, 32'd0);
    tick();
    chk("t3_eu_ale", {31'd0, ale}, 32'd1);
    chk("t3_eu_dir", {12'd0, Direction}, 32'h00012350);
    tick();
    chk("t3_eu_rdwr", {31'd0, RD_WR}, 32'd0);
    repeat (2) tick();
    chk("t3_eu_ack", {31'd0, eu_ack}, 32'd1);
    chk("t3_eu_rdata", {24'd0, eu_rdata}, {24'd0, (sb_eu.size() > 0) ? sb_eu.pop_front() : 8'hxx});
    eu_req = 1'b0;
    tick();
    chk("t3_ack_pulse", {31'd0, eu_ack}, 32'd0);
    chk("t3_rdata_hold", {24'd0, eu_rdata}, 32'h000000A5);

    // 4: EU write with three wait states
    eu_req = 1'b1; eu_wr = 1'b1; eu_off = 16'h0020; eu_wdata = 8'h3C; ready = 1'b0;
    tick();
    chk("t4_dir", {12'd0, Direction}, 32'h00012360);
    chk("t4_oe_t1", {31'd0, Data_oe}, 32'd0);
    tick();
    chk("t4_rdwr_t2", {31'd0, RD_WR}, 32'd1);
    chk("t4_oe_t2", {31'd0, Data_oe}, 32'd1);
    chk("t4_dout", {24'd0, Data_out}, 32'h0000003C);
    tick();
    for (int w = 0; w < 3; w++) begin
      tick();
      chk("t4_tw_noack", {31'd0, eu_ack}, 32'd0);
      chk("t4_tw_oe", {31'd0, Data_oe}, 32'd1);
    end
    ready = 1'b1;
    tick();
    chk("t4_ack", {31'd0, eu_ack}, 32'd1);
    chk("t4_rdwr_t4", {31'd0, RD_WR}, 32'd1);
    chk("t4_oe_t4", {31'd0, Data_oe}, 32'd1);
    eu_req = 1'b0;
    tick();
    chk("t4_rdwr_idle", {31'd0, RD_WR}, 32'd0);
    chk("t4_oe_idle", {31'd0, Data_oe}, 32'd0);
    chk("t4_rdata_kept", {24'd0, eu_rdata}, 32'h000000A5);

    // 5: ip_load during prefetch T3
    pop_one();
    chk("t5_pf_dir", {12'd0, Direction}, 32'h00000009);
    repeat (2) tick();
    ip_load = 1'b1; ip_new = 16'h0100;
    tick();
    ip_load = 1'b0;
    chk("t5_flush", {31'd0, q_valid}, 32'd0);
    sb_q.delete();
    push_exp(20'h000F0, 2);
    tick();
    chk("t5_dropped", {31'd0, q_valid}, 32'd0);
    chk("t5_ale", {31'd0, ale}, 32'd1);
    chk("t5_dir", {12'd0, Direction}, 32'h000000F0);
    drain(2);

    // 6: asynchronous reset in T3
    begin
      int t = 0;
      tick();
      while (ale !== 1'b1 && t < 20) begin
        tick();
        t++;
      end
      chk("t6_found_t1", {31'd0, ale}, 32'd1);
    end
    repeat (2) tick();
    #2 reset = 1'b0;
    #1;
    chk("t6_rst_dir", {12'd0, Direction}, 32'd0);
    chk("t6_rst_qv", {31'd0, q_valid}, 32'd0);
    chk("t6_rst_qbyte", {24'd0, q_byte}, 32'd0);
    chk("t6_rst_rdata", {24'd0, eu_rdata}, 32'd0);
    chk("t6_rst_dout", {24'd0, Data_out}, 32'd0);
    tick();
    #2 reset = 1'b1;
    #1;
    chk("t6_rel_qv", {31'd0, q_valid}, 32'd0);
    chk("t6_rel_ale", {31'd0, ale}, 32'd0);
    tick();
    chk("t6_restart_dir", {12'd0, Direction}, 32'h000FFFF0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
